// File: rtl/rca_config_pkg.sv
// rca_config: shared RCA constants and the LSQ entry/state types.
package rca_config;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned GRID_NUM_ROWS = 4;

   // One queued memory operation as captured from a grid row.
   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [2:0]      fn3;
      logic            load;
      logic            store;
   } rca_lsq_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      ISSUE,
      RELEASE
   } rca_lsq_state_t;

endpackage

// File: rtl/rca_lsq_scheduler_fifo.sv
// rca_lsq_fifo: small issue FIFO of rca_lsq_entry_t with an explicit
// occupancy count so full and empty are unambiguous when pointers meet.
module rca_lsq_fifo
   import rca_config::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  rca_lsq_entry_t                push_entry,
   input  logic                          pop,
   output rca_lsq_entry_t                head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   rca_lsq_entry_t mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   // A pop on a full FIFO frees the slot this same cycle's push lands in.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/rca_lsq_scheduler.sv
// rca_lsq_scheduler: captures per-row grid load/store requests, serialises
// them in row order into the issue FIFO and drives the shared LSU while
// holding rca_lsu_lock.
// Optional: define RCA_LSQ_PERF_COUNTERS_EN for perf_issued,
// perf_lsu_stall and perf_grid_stall saturating counters.
module rca_lsq_scheduler
   import rca_config::*;
#(
   parameter int unsigned NUM_ROWS   = GRID_NUM_ROWS,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_ROWS-1:0][XLEN-1:0]  grid_addr,
   input  logic [NUM_ROWS-1:0][XLEN-1:0]  grid_data,
   input  logic [NUM_ROWS-1:0][XLEN-1:0]  grid_fn3,
   input  logic [NUM_ROWS-1:0]            grid_load,
   input  logic [NUM_ROWS-1:0]            grid_store,
   input  logic [NUM_ROWS-1:0]            grid_new_request,
   output logic                           grid_fifo_full,
   output logic [XLEN-1:0]                lsu_rs1,
   output logic [XLEN-1:0]                lsu_rs2,
   output logic [2:0]                     lsu_fn3,
   output logic                           lsu_load,
   output logic                           lsu_store,
   output logic                           lsu_new_request,
   output logic                           rca_lsu_lock,
   input  logic                           lsu_ready
`ifdef RCA_LSQ_PERF_COUNTERS_EN
   ,
   output logic [31:0]                    perf_issued,
   output logic [31:0]                    perf_lsu_stall,
   output logic [31:0]                    perf_grid_stall
`endif
);

   localparam int unsigned IW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   rca_lsq_state_t      state;
   rca_lsq_state_t      state_next;
   rca_lsq_entry_t      slot [NUM_ROWS];
   logic [NUM_ROWS-1:0] slot_valid;
   logic [NUM_ROWS-1:0] slot_valid_next;
   logic [NUM_ROWS-1:0] accept;
   logic                any_accept;
   logic                sel_valid;
   logic [IW-1:0]       sel_idx;
   rca_lsq_entry_t      fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CW-1:0]       fifo_count;
   logic [CW-1:0]       count_next;
   logic                push;
   logic                pop;
   logic                issue;
   logic                full_next;
   logic                unused_fn3_hi;

   // Row acceptance: only while not back-pressured and with exactly one of load/store.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
         accept[i] = grid_new_request[i] && !grid_fifo_full && (grid_load[i] ^ grid_store[i]);
      end
   end

   assign any_accept = |accept;

   // Only funct3[2:0] is meaningful; upper bits are deliberately ignored.
   always_comb begin
      unused_fn3_hi = 1'b0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
         unused_fn3_hi = unused_fn3_hi ^ (^grid_fn3[i][XLEN-1:3]);
      end
   end

   // Fixed-priority encoder: lowest row index is oldest in program order.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = NUM_ROWS; i > 0; i--) begin
         if (slot_valid[i-1]) begin
            sel_valid = 1'b1;
            sel_idx   = IW'(i - 1);
         end
      end
   end

   assign pop  = issue && lsu_ready;
   assign push = sel_valid && (!fifo_full || pop);

   // Next slot occupancy and registered back-pressure derived from next-cycle state.
   always_comb begin
      slot_valid_next = slot_valid;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
         if (accept[i]) begin
            slot_valid_next[i] = 1'b1;
         end else if (push && (sel_idx == IW'(i))) begin
            slot_valid_next[i] = 1'b0;
         end
      end
      count_next = fifo_count + CW'(push) - CW'(pop);
      full_next  = (|slot_valid_next) ||
                   (int'(count_next) > (int'(FIFO_DEPTH) - int'(NUM_ROWS)));
   end

   // Slot valid bits, back-pressure flag and FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid     <= '0;
         grid_fifo_full <= 1'b0;
         state          <= IDLE;
      end else begin
         slot_valid     <= slot_valid_next;
         grid_fifo_full <= full_next;
         state          <= state_next;
      end
   end

   // Slot payload capture; payload is qualified by slot_valid.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
         if (accept[i]) begin
            slot[i] <= '{addr:  grid_addr[i],
                         data:  grid_data[i],
                         fn3:   grid_fn3[i][2:0],
                         load:  grid_load[i],
                         store: grid_store[i]};
         end
      end
   end

   rca_lsq_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (slot[sel_idx]),
      .pop        (pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // LSU ownership FSM: next state, lock and issue-valid.
   always_comb begin
      state_next   = state;
      rca_lsu_lock = 1'b1;
      issue        = 1'b0;
      case (state)
         IDLE: begin
            rca_lsu_lock = 1'b0;
            if (any_accept) state_next = ACQUIRE;
         end
         ACQUIRE: begin
            if (lsu_ready) state_next = ISSUE;
         end
         ISSUE: begin
            issue = !fifo_empty;
            // An empty FIFO implies no pop this cycle.
            if (!(|slot_valid) && fifo_empty && !any_accept) state_next = RELEASE;
         end
         RELEASE: begin
            if (any_accept) begin
               state_next = ISSUE;
            end else if (lsu_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next   = IDLE;
            rca_lsu_lock = 1'b0;
         end
      endcase
   end

   // Head of FIFO to the LSU; zero whenever no operation is being offered.
   assign lsu_new_request = issue;
   assign lsu_rs1         = issue ? fifo_head.addr  : '0;
   assign lsu_rs2         = issue ? fifo_head.data  : '0;
   assign lsu_fn3         = issue ? fifo_head.fn3   : '0;
   assign lsu_load        = issue && fifo_head.load;
   assign lsu_store       = issue && fifo_head.store;

`ifdef RCA_LSQ_PERF_COUNTERS_EN
   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued     <= '0;
         perf_lsu_stall  <= '0;
         perf_grid_stall <= '0;
      end else begin
         if (pop && (perf_issued != '1)) perf_issued <= perf_issued + 32'd1;
         if (issue && !lsu_ready && (perf_lsu_stall != '1)) perf_lsu_stall <= perf_lsu_stall + 32'd1;
         if (grid_fifo_full && (|grid_new_request) && (perf_grid_stall != '1)) begin
            perf_grid_stall <= perf_grid_stall + 32'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   // Flag rows that present load and store together; such requests are dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            assert (!(grid_new_request[i] && !grid_fifo_full && grid_load[i] && grid_store[i]))
               else $warning("rca_lsq_scheduler: row %0d presented load and store together, request dropped", i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_rca_lsq_scheduler.sv
// tb_rca_lsq_scheduler: directed, table-driven bench for rca_lsq_scheduler.
module tb_rca_lsq_scheduler;
   import rca_config::*;

   localparam int unsigned NR = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NR-1:0][XLEN-1:0] grid_addr;
   logic [NR-1:0][XLEN-1:0] grid_data;
   logic [NR-1:0][XLEN-1:0] grid_fn3;
   logic [NR-1:0]           grid_load;
   logic [NR-1:0]           grid_store;
   logic [NR-1:0]           grid_new_request;
   logic                    grid_fifo_full;
   logic [XLEN-1:0]         lsu_rs1;
   logic [XLEN-1:0]         lsu_rs2;
   logic [2:0]              lsu_fn3;
   logic                    lsu_load;
   logic                    lsu_store;
   logic                    lsu_new_request;
   logic                    rca_lsu_lock;
   logic                    lsu_ready;
`ifdef RCA_LSQ_PERF_COUNTERS_EN
   logic [31:0]             perf_issued;
   logic [31:0]             perf_lsu_stall;
   logic [31:0]             perf_grid_stall;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rca_lsq_scheduler #(
      .NUM_ROWS   (NR),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .grid_addr        (grid_addr),
      .grid_data        (grid_data),
      .grid_fn3         (grid_fn3),
      .grid_load        (grid_load),
      .grid_store       (grid_store),
      .grid_new_request (grid_new_request),
      .grid_fifo_full   (grid_fifo_full),
      .lsu_rs1          (lsu_rs1),
      .lsu_rs2          (lsu_rs2),
      .lsu_fn3          (lsu_fn3),
      .lsu_load         (lsu_load),
      .lsu_store        (lsu_store),
      .lsu_new_request  (lsu_new_request),
      .rca_lsu_lock     (rca_lsu_lock),
      .lsu_ready        (lsu_ready)
`ifdef RCA_LSQ_PERF_COUNTERS_EN
      ,
      .perf_issued      (perf_issued),
      .perf_lsu_stall   (perf_lsu_stall),
      .perf_grid_stall  (perf_grid_stall)
`endif
   );

   // Row i gets addr = abase + 16*i, data = 0x11*i, fn3 = fn3b + i with junk upper bits.
   task automatic drive(input logic r, input logic [NR-1:0] req, input logic [NR-1:0] ld,
                        input logic [NR-1:0] st, input logic rdy, input logic [31:0] abase,
                        input logic [2:0] fn3b);
      logic [2:0] f;
      rst              = r;
      grid_new_request = req;
      grid_load        = ld;
      grid_store       = st;
      lsu_ready        = rdy;
      for (int i = 0; i < int'(NR); i++) begin
         f            = fn3b + 3'(i);
         grid_addr[i] = abase + 32'(i) * 32'h10;
         grid_data[i] = 32'h11 * 32'(i);
         grid_fn3[i]  = 32'hDEAD_BEE8 | {29'd0, f};
      end
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, '0, '0, '0, rdy, 32'h0, 3'd0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic        r;
      logic [3:0]  req;
      logic [3:0]  ld;
      logic [3:0]  st;
      logic        rdy;
      logic [31:0] abase;
      logic [2:0]  fn3b;
      logic        e_full;
      logic        e_lock;
      logic        e_nreq;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_ld;
      logic        e_st;
      logic [2:0]  e_fn3;
   } vec_t;

   vec_t vecs [18];

   task automatic wait_unlock(input string name);
      int n;
      n = 0;
      while (rca_lsu_lock !== 1'b0 && n < 20) begin
         @(negedge clk);
         idle(1'b1);
         n++;
      end
      check(name, {31'd0, rca_lsu_lock}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_q [$];
      int          issued;
      int          outstanding;
      int          batch;
      int          viol;
      int          cyc;
      logic        rdy;

      // Each record: inputs for this cycle | outputs expected in this cycle.
      //               r     req      ld       st       rdy   abase         fn3b    full  lock  nreq  rs1           rs2         ld    st    fn3
      vecs[0]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 32'h0000_1000, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_1000, 3'd2, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_1000, 3'd2, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0,      1'b1, 1'b0, 3'd2};
      vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[5]  = '{1'b0, 4'b1011, 4'b0000, 4'b1011, 1'b1, 32'h0000_4000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 32'h0000_4000, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0,      1'b0, 1'b1, 3'd0};
      vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4010, 32'h11,     1'b0, 1'b1, 3'd1};
      vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4030, 32'h33,     1'b0, 1'b1, 3'd3};
      vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[12] = '{1'b0, 4'b0101, 4'b0101, 4'b0100, 1'b1, 32'h0000_5000, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0,      1'b1, 1'b0, 3'd4};
      vecs[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};
      vecs[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0,         3'd0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,      1'b0, 1'b0, 3'd0};

      drive(1'b1, '0, '0, '0, 1'b0, 32'h0, 3'd0);
      repeat (2) @(posedge clk);

      // Single load, batch ordering with an ignored request, illegal-request drop.
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         check($sformatf("v%0d_full", k), {31'd0, grid_fifo_full},  {31'd0, vecs[k].e_full});
         check($sformatf("v%0d_lock", k), {31'd0, rca_lsu_lock},    {31'd0, vecs[k].e_lock});
         check($sformatf("v%0d_nreq", k), {31'd0, lsu_new_request}, {31'd0, vecs[k].e_nreq});
         check($sformatf("v%0d_rs1", k),  lsu_rs1,                  vecs[k].e_rs1);
         check($sformatf("v%0d_rs2", k),  lsu_rs2,                  vecs[k].e_rs2);
         check($sformatf("v%0d_load", k), {31'd0, lsu_load},        {31'd0, vecs[k].e_ld});
         check($sformatf("v%0d_store", k), {31'd0, lsu_store},      {31'd0, vecs[k].e_st});
         check($sformatf("v%0d_fn3", k),  {29'd0, lsu_fn3},         {29'd0, vecs[k].e_fn3});
         drive(vecs[k].r, vecs[k].req, vecs[k].ld, vecs[k].st, vecs[k].rdy, vecs[k].abase, vecs[k].fn3b);
      end

      // LSU back-pressure: five not-ready cycles with head at 0x2000.
      @(negedge clk);
      drive(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 32'h0000_2000, 3'd3);
      @(negedge clk);
      idle(1'b1);
      @(negedge clk);
      check("bp_nreq_first", {31'd0, lsu_new_request}, 32'd1);
      check("bp_rs1_first", lsu_rs1, 32'h0000_2000);
      idle(1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp_nreq_hold%0d", k), {31'd0, lsu_new_request}, 32'd1);
         check($sformatf("bp_rs1_hold%0d", k), lsu_rs1, 32'h0000_2000);
         check($sformatf("bp_fn3_hold%0d", k), {29'd0, lsu_fn3}, 32'd3);
         idle(k == 4);
      end
      @(negedge clk);
      check("bp_popped_once", {31'd0, lsu_new_request}, 32'd0);
      idle(1'b1);
      wait_unlock("bp_unlock");

      // FIFO wrap: three batches of four loads, lsu_ready toggling.
      issued      = 0;
      outstanding = 0;
      batch       = 0;
      viol        = 0;
      cyc         = 0;
      while (issued < 12 && cyc < 400) begin
         @(negedge clk);
         if (outstanding > 0 && grid_fifo_full !== 1'b1) viol++;
         rdy = cyc[0];
         if (lsu_new_request === 1'b1 && rdy) begin
            if (exp_q.size() > 0) begin
               check($sformatf("wrap_rs1_%0d", issued), lsu_rs1, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               check($sformatf("wrap_extra_%0d", issued), lsu_rs1, 32'hFFFF_FFFF);
            end
            issued++;
            outstanding--;
         end
         if (grid_fifo_full === 1'b0 && batch < 3) begin
            drive(1'b0, 4'b1111, 4'b1111, 4'b0000, rdy, 32'h0000_8000 + 32'(batch) * 32'h100, 3'd0);
            for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_8000 + 32'(batch) * 32'h100 + 32'(i) * 32'h10);
            outstanding += 4;
            batch++;
         end else begin
            idle(rdy);
         end
         cyc++;
      end
      check("wrap_issued", 32'(issued), 32'd12);
      check("wrap_full_invariant", 32'(viol), 32'd0);
      check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
      wait_unlock("wrap_unlock");

      // Reset while issuing with three entries queued.
      @(negedge clk);
      drive(1'b0, 4'b0111, 4'b0111, 4'b0000, 1'b0, 32'h0000_9000, 3'd0);
      @(negedge clk);
      idle(1'b1);
      @(negedge clk);
      check("rst_pre_nreq", {31'd0, lsu_new_request}, 32'd1);
      idle(1'b0);
      @(negedge clk);
      idle(1'b0);
      @(negedge clk);
      check("rst_pre_rs1", lsu_rs1, 32'h0000_9000);
      drive(1'b1, '0, '0, '0, 1'b0, 32'h0, 3'd0);
      @(negedge clk);
      check("rst_lock", {31'd0, rca_lsu_lock}, 32'd0);
      check("rst_nreq", {31'd0, lsu_new_request}, 32'd0);
      check("rst_full", {31'd0, grid_fifo_full}, 32'd0);
      check("rst_rs1", lsu_rs1, 32'd0);
      idle(1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("rst_no_stale_nreq%0d", k), {31'd0, lsu_new_request}, 32'd0);
         check($sformatf("rst_no_stale_lock%0d", k), {31'd0, rca_lsu_lock}, 32'd0);
         idle(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rca_lsq_scheduler.md
Name: rca_lsq_scheduler

Overview:
- Shares the single core load/store unit between the GRID_NUM_ROWS memory rows of the reconfigurable compute array (RCA) grid.
- Captures per-row load/store requests from the grid side (rca_lsq_grid_interface signal set) and serialises them in row order into a small FIFO.
- Acquires the LSU through rca_lsu_lock and issues one operation per accepted handshake on the rca_lsu_interface signal set.
- Sits between the RCA grid and the LSU's RCA input mux.

Parameters:
- NUM_ROWS, default GRID_NUM_ROWS (4): number of grid rows with memory access.
- FIFO_DEPTH, default 4: entries in the issue FIFO. Must be a power of two and at least 2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- grid_addr  in  [NUM_ROWS] x XLEN  effective address per row (offset already added)
- grid_data  in  [NUM_ROWS] x XLEN  store data per row
- grid_fn3  in  [NUM_ROWS] x XLEN  funct3 per row; only bits [2:0] are used
- grid_load  in  [NUM_ROWS] x 1  row operation is a load
- grid_store  in  [NUM_ROWS] x 1  row operation is a store
- grid_new_request  in  [NUM_ROWS] x 1  row presents a request this cycle
- grid_fifo_full  out  1  back-pressure to the grid: no new requests may be presented
- lsu_rs1  out  XLEN  address to the LSU
- lsu_rs2  out  XLEN  store data to the LSU
- lsu_fn3  out  3  funct3 to the LSU
- lsu_load  out  1  issued operation is a load
- lsu_store  out  1  issued operation is a store
- lsu_new_request  out  1  issue valid
- rca_lsu_lock  out  1  RCA owns the LSU
- lsu_ready  in  1  LSU can accept an operation

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all row slots invalid; FIFO empty; state IDLE; grid_fifo_full=0, lsu_new_request=0, rca_lsu_lock=0, lsu_load=0, lsu_store=0; lsu_rs1, lsu_rs2 and lsu_fn3 are 0.
- Row slots: each row has a 1-entry slot.
  - On grid_new_request[i]=1 with grid_fifo_full=0, the row's addr, data, fn3[2:0], load and store are captured at the clock edge.
  - A request with load=store=0, or with load=store=1, is dropped and never issued. Simulation also flags load=store=1 with an assertion.
- grid_fifo_full (registered): equals 1 when any slot is valid or FIFO occupancy exceeds FIFO_DEPTH-NUM_ROWS.
  - Requests presented while grid_fifo_full=1 are ignored.
  - A whole batch is therefore drained from the slots before the next batch is accepted, which preserves program order.
- Serialisation: each cycle, the lowest-index valid slot moves into the FIFO if the FIFO is not full, and that slot clears.
  - Fixed priority is used; round-robin is not permitted because row index encodes program order.
- Issue: lsu_new_request = (state==ISSUE) && FIFO not empty.
  - The outputs are driven from the FIFO head.
  - The head is popped on lsu_new_request && lsu_ready.
  - Outputs hold stable while lsu_ready=0.
- FSM:
  - IDLE: lock=0. Any accepted grid request -> ACQUIRE.
  - ACQUIRE: lock=1, no issue. Minimum 1 cycle. Goes to ISSUE when lsu_ready=1.
  - ISSUE: lock=1. When slots and FIFO are empty, there is no pop this cycle and no incoming request -> RELEASE.
  - RELEASE: lock=1, no issue. An incoming request -> ISSUE. Otherwise, when lsu_ready=1 -> IDLE. lsu_ready=1 means the last op has been accepted and the LSU is quiescent.
- Latency: a request accepted at edge t enters the FIFO at edge t+1. The earliest lsu_new_request is in cycle t+2, given lsu_ready=1 in ACQUIRE.
- Simultaneous events: a push and a pop in the same cycle keep occupancy unchanged. A pop on a full FIFO lets a slot push in the same cycle.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrapping naturally. An explicit count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Reset mid-operation: all state is cleared at the next edge. Lock and issue drop in that cycle, and in-flight entries are discarded.

Optional Feature:
- Macro: RCA_LSQ_PERF_COUNTERS_EN.
- With the macro defined, three extra outputs are present, all 32 bits, saturating, and cleared by rst:
  - perf_issued: pops.
  - perf_lsu_stall: cycles with lsu_new_request && !lsu_ready.
  - perf_grid_stall: cycles with grid_fifo_full && any grid_new_request.
- Without the macro, these ports and their logic do not exist.

Decomposition:
- rca_config:
  - typedef rca_lsq_entry_t {addr, data, fn3[2:0], load, store}.
  - typedef rca_lsq_state_t enum {IDLE, ACQUIRE, ISSUE, RELEASE}.
  - Existing GRID_NUM_ROWS.
- Sub-module rca_lsq_fifo: parameterised by FIFO_DEPTH, holds rca_lsq_entry_t, and exposes push, pop, full, empty and count.
- Priority encoder and FSM live in rca_lsq_scheduler.

Test Plan:
- Single load: row 0 load at addr 0x1000, fn3=2, lsu_ready=1.
  -> lock rises at t+1; lsu_new_request in cycle t+2 with rs1=0x1000, lsu_fn3=2, lsu_load=1.
  -> IDLE and lock=0 two cycles after the pop.
- Batch ordering: rows 3, 1, 0 request in the same cycle (stores with data 0x33, 0x11, 0x00).
  -> issue order is rows 0, 1, 3; grid_fifo_full=1 until all slots drain.
- LSU back-pressure: lsu_ready=0 for 5 cycles during ISSUE with the head at addr 0x2000.
  -> lsu_new_request and rs1=0x2000 held stable; pop occurs only on the first ready cycle.
- FIFO full and wrap: FIFO_DEPTH=4, 3 batches of 4 requests, lsu_ready toggling 1/0.
  -> all 12 ops issued in order; pointers wrap; no loss or duplication; grid_fifo_full is never 0 while count > 0.
- Illegal request: load=store=1 on row 2 together with a valid load on row 0.
  -> only the row 0 op is issued; the row 2 request is dropped.
- Reset in ISSUE with 3 FIFO entries: rst asserted for 1 cycle.
  -> the next cycle shows lock=0, lsu_new_request=0, grid_fifo_full=0; no stale issue after reset.
